pwm_cfg_shadow_bank: RTL

Multi-channel PWM configuration register bank with double buffering. Software writes land in a per-channel shadow word. A commit copies shadow to active, either immediately or at the channel's next carrier sync event, so configuration never changes mid-period. It sits between the AXI register slice and the N PWM carrier/comparator channels and drives their packed configuration words. It also provides a global kill and a registered readback port.

---
 rtl/pwm_cfg_shadow_bank_pkg.sv | 27 ++
 rtl/pwm_cfg_shadow_bank_channel.sv | 90 +++++++++
 rtl/pwm_cfg_shadow_bank.sv | 95 +++++++++
 3 files changed

// File: rtl/pwm_cfg_shadow_bank_pkg.sv
// Shared types and constants for the PWM configuration shadow bank.
//   cfg_word_t  : packed per-channel config word {pwm_onoff, int_onoff, mask_mode, count_mode}
//   cfg_state_t : per-channel commit FSM state
package pwm_cfg_shadow_bank_pkg;

    localparam int CNT_MODE_W = 2;
    localparam int CFG_W      = 3 + CNT_MODE_W;

    localparam logic [CNT_MODE_W-1:0] CNT_UP = '0;

    typedef struct packed {
        logic                  pwm_onoff;
        logic                  int_onoff;
        logic                  mask_mode;
        logic [CNT_MODE_W-1:0] count_mode;
    } cfg_word_t;

    // PWM off, interrupt off, mask 0, count up.
    localparam cfg_word_t CFG_RESET = '{pwm_onoff: 1'b0, int_onoff: 1'b0,
                                        mask_mode: 1'b0, count_mode: CNT_UP};

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_ARMED = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/pwm_cfg_shadow_bank_channel.sv
// One PWM channel: shadow word, active word and the IDLE/ARMED commit FSM.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   wr_sel, wr_data: shadow write (already decoded for this channel)
//   commit_req     : commit addressed to this channel (mask applied)
//   commit_sync    : 1 = wait for sync_evt, 0 = load now
//   commit_abort   : cancel an armed commit (mask applied)
//   sync_evt       : carrier period boundary of this channel
//   kill           : global safe-off, forces active pwm_onoff low
//   shadow_cfg     : current shadow word
//   active_cfg     : current active word (registered)
//   pending        : armed deferred commit
//   commit_done    : one-cycle pulse after the active word was loaded
module pwm_cfg_channel
    import pwm_cfg_shadow_bank_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_sel,
    input  logic [CFG_W-1:0] wr_data,
    input  logic             commit_req,
    input  logic             commit_sync,
    input  logic             commit_abort,
    input  logic             sync_evt,
    input  logic             kill,
    output logic [CFG_W-1:0] shadow_cfg,
    output logic [CFG_W-1:0] active_cfg,
    output logic             pending,
    output logic             commit_done
);

    cfg_state_t state, state_nxt;
    cfg_word_t  shadow_q, shadow_nxt;
    cfg_word_t  active_q, active_nxt;
    logic       load;
    logic       done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG_IDLE;
            shadow_q <= CFG_RESET;
            active_q <= CFG_RESET;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            shadow_q <= shadow_nxt;
            active_q <= active_nxt;
            done_q   <= load;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        // A load in the same cycle as a write picks up the new data.
        shadow_nxt = wr_sel ? cfg_word_t'(wr_data) : shadow_q;

        if (commit_abort) begin
            // Abort beats any concurrent request or sync event.
            state_nxt = CFG_IDLE;
        end else begin
            case (state)
                CFG_IDLE: begin
                    if (commit_req) begin
                        // A sync event coinciding with a deferred request
                        // loads right away and never arms.
                        if (!commit_sync || sync_evt) load = 1'b1;
                        else                          state_nxt = CFG_ARMED;
                    end
                end
                CFG_ARMED: begin
                    if (sync_evt) begin
                        load      = 1'b1;
                        state_nxt = CFG_IDLE;
                    end
                end
                default: state_nxt = CFG_IDLE;
            endcase
        end

        active_nxt = load ? shadow_nxt : active_q;
        if (kill) active_nxt.pwm_onoff = 1'b0;
    end

    assign shadow_cfg  = shadow_q;
    assign active_cfg  = active_q;
    assign pending     = (state == CFG_ARMED);
    assign commit_done = done_q;

endmodule

// File: rtl/pwm_cfg_shadow_bank.sv
// Multi-channel PWM configuration bank with double buffering.
// Writes land in per-channel shadow words; commits copy shadow to active
// either immediately or at the channel's next carrier sync event.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   wr_en, wr_ch, wr_data          : shadow write
//   wr_err                         : one-cycle pulse on write/read to channel >= N_CH
//   commit_req, commit_mask,
//   commit_sync, commit_abort      : commit control
//   sync_evt                       : per-channel carrier period boundary
//   kill                           : global safe-off
//   pending, commit_done           : per-channel commit status
//   active_cfg                     : packed active words, channel i at [i*CFG_W +: CFG_W]
//   rd_en, rd_ch, rd_src           : readback request (rd_src 0 shadow, 1 active)
//   rd_valid, rd_data              : registered readback response
module pwm_cfg_shadow_bank
    import pwm_cfg_shadow_bank_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [CFG_W-1:0]      wr_data,
    output logic                  wr_err,
    input  logic                  commit_req,
    input  logic [N_CH-1:0]       commit_mask,
    input  logic                  commit_sync,
    input  logic                  commit_abort,
    input  logic [N_CH-1:0]       sync_evt,
    input  logic                  kill,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       commit_done,
    output logic [N_CH*CFG_W-1:0] active_cfg,
    input  logic                  rd_en,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic                  rd_src,
    output logic                  rd_valid,
    output logic [CFG_W-1:0]      rd_data
);

    logic [N_CH-1:0]            wr_sel;
    logic [N_CH-1:0]            rd_hit;
    logic [N_CH-1:0][CFG_W-1:0] shadow_w;
    logic [N_CH-1:0][CFG_W-1:0] active_w;
    logic [CFG_W-1:0]           rd_word;

    // Decode by equality against each channel so an index wider than the
    // channel count never aliases onto a real channel.
    always_comb begin
        wr_sel  = '0;
        rd_hit  = '0;
        rd_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_sel[i] = wr_en && (wr_ch == CH_W'(i));
            rd_hit[i] = (rd_ch == CH_W'(i));
            if (rd_hit[i]) rd_word = rd_src ? active_w[i] : shadow_w[i];
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_cfg_channel u_ch (
            .clk          (clk),
            .rst          (rst),
            .wr_sel       (wr_sel[g]),
            .wr_data      (wr_data),
            .commit_req   (commit_req && commit_mask[g]),
            .commit_sync  (commit_sync),
            .commit_abort (commit_abort && commit_mask[g]),
            .sync_evt     (sync_evt[g]),
            .kill         (kill),
            .shadow_cfg   (shadow_w[g]),
            .active_cfg   (active_w[g]),
            .pending      (pending[g]),
            .commit_done  (commit_done[g])
        );
        assign active_cfg[g*CFG_W +: CFG_W] = active_w[g];
    end

    // Readback samples pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_err   <= (wr_en && !(|wr_sel)) || (rd_en && !(|rd_hit));
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule
